// File: rtl/agex_pkg.sv
// Shared definitions for the AGEX stage: widths, internal opcodes,
// MUL sequencer states and the AGEX latch layout seen by MEM.
package agex_pkg;

  localparam int DBITS     = 32;
  localparam int INSTBITS  = 32;
  localparam int IOPBITS   = 6;
  localparam int REGNOBITS = 5;

  // Internal opcodes produced by decode
  typedef enum logic [IOPBITS-1:0] {
    ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLT_I, SLTU_I, SRA_I, SRL_I, SLL_I,
    MUL_I,
    ADDI_I, ANDI_I, ORI_I, XORI_I, SLTI_I, SLTIU_I, SRAI_I, SRLI_I, SLLI_I,
    LUI_I, AUIPC_I,
    LW_I, SW_I,
    JAL_I, JALR_I,
    BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I,
    CSRR_I, CSRW_I,
    INVALID_I
  } op_e;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // AGEX latch, most-significant field first
  typedef struct packed {
    logic                 valid;
    logic [INSTBITS-1:0]  inst;
    logic [DBITS-1:0]     pc;
    logic [IOPBITS-1:0]   op;
    logic [DBITS-1:0]     inst_count;
    logic [DBITS-1:0]     result;
    logic [DBITS-1:0]     store_data;
    logic                 wr_reg;
    logic [REGNOBITS-1:0] wregno;
  } agex_latch_t;

  localparam int AGEX_latch_WIDTH      = $bits(agex_latch_t);
  // stall + wr_reg + wregno
  localparam int from_AGEX_to_DE_WIDTH = 2 + REGNOBITS;
  // redirect + redirect_pc
  localparam int from_AGEX_to_FE_WIDTH = 1 + DBITS;

endpackage

// File: rtl/agex_if.sv
// DE -> AGEX inputs and AGEX -> MEM/DE/FE outputs grouped as one bundle.
// master = upstream/testbench side, slave = the AGEX stage.
interface agex_if;
  import agex_pkg::*;

  logic                 valid_i;
  logic [INSTBITS-1:0]  inst_i;
  logic [DBITS-1:0]     pc_i;
  logic [DBITS-1:0]     pcplus_i;
  logic [IOPBITS-1:0]   op_i;
  logic [DBITS-1:0]     inst_count_i;
  logic [DBITS-1:0]     imm_i;
  logic [DBITS-1:0]     rs1_val_i;
  logic [DBITS-1:0]     rs2_val_i;

  logic                 stall_o;
  logic [REGNOBITS-1:0] agex_wregno_o;
  logic                 agex_wr_reg_o;
  logic                 redirect_o;
  logic [DBITS-1:0]     redirect_pc_o;
  logic                 valid_o;
  logic [INSTBITS-1:0]  inst_o;
  logic [DBITS-1:0]     pc_o;
  logic [DBITS-1:0]     inst_count_o;
  logic [IOPBITS-1:0]   op_o;
  logic [DBITS-1:0]     result_o;
  logic [DBITS-1:0]     store_data_o;
  logic                 wr_reg_o;
  logic [REGNOBITS-1:0] wregno_o;

  modport master (
    output valid_i, inst_i, pc_i, pcplus_i, op_i, inst_count_i, imm_i,
           rs1_val_i, rs2_val_i,
    input  stall_o, agex_wregno_o, agex_wr_reg_o, redirect_o, redirect_pc_o,
           valid_o, inst_o, pc_o, inst_count_o, op_o, result_o, store_data_o,
           wr_reg_o, wregno_o
  );

  modport slave (
    input  valid_i, inst_i, pc_i, pcplus_i, op_i, inst_count_i, imm_i,
           rs1_val_i, rs2_val_i,
    output stall_o, agex_wregno_o, agex_wr_reg_o, redirect_o, redirect_pc_o,
           valid_o, inst_o, pc_o, inst_count_o, op_o, result_o, store_data_o,
           wr_reg_o, wregno_o
  );

endinterface

// File: rtl/agex_mul_seq.sv
// Multi-cycle MUL sequencer. The MUL stays presented on the inputs for
// MUL_LAT cycles; busy stalls upstream for the first MUL_LAT-1 of them and
// done marks the cycle whose product may be latched. Operands are read live.
module agex_mul_seq
  import agex_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [DBITS-1:0] a,
  input  logic [DBITS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [DBITS-1:0] product
);

  localparam int         CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_LAT - 1);

  mul_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and cycle counter register; reset drops any MUL in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MUL_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, stall and completion decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (start) begin
          if (MUL_LAT == 1) begin
            done = 1'b1;
          end else begin
            busy      = 1'b1;
            state_nxt = MUL_BUSY;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      MUL_BUSY: begin
        if (abort) begin
          state_nxt = MUL_IDLE;
          cnt_nxt   = '0;
        end else if (cnt < LAST) begin
          busy    = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          done      = 1'b1;
          state_nxt = MUL_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = MUL_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Low DBITS of the product; upper half is never needed
  assign product = a * b;

endmodule

// File: rtl/agex_stage.sv
// Execute / address-generation stage. Computes ALU, MUL, memory address and
// branch/jump outcome from the DE latch, registers the AGEX latch for MEM,
// stalls DE during multi-cycle MUL, redirects FE on taken control transfers
// and squashes the two wrong-path slots that follow a redirect.
module agex_stage
  import agex_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic  clk,
  input  logic  reset,
  agex_if.slave bus
);

  op_e                  op;
  logic [REGNOBITS-1:0] rd;
  logic [1:0]           squash_cnt;
  logic                 squash_p0;
  logic                 vld_p0;
  logic                 mul_start, mul_abort, mul_busy, mul_done;
  logic [DBITS-1:0]     mul_product;
  logic [DBITS-1:0]     result_p0;
  logic [DBITS-1:0]     target_p0;
  logic [DBITS-1:0]     jalr_sum;
  logic                 taken_p0;
  logic                 wr_p0;

  agex_latch_t          latch_p1;
  logic                 redirect_p1;
  logic [DBITS-1:0]     redirect_pc_p1;

  function automatic logic [DBITS-1:0] alu_op(input op_e o,
                                              input logic [DBITS-1:0] a,
                                              input logic [DBITS-1:0] b);
    logic signed [DBITS-1:0] as_v, bs_v;
    logic [4:0]              sh;
    as_v = signed'(a);
    bs_v = signed'(b);
    sh   = b[4:0];
    case (o)
      ADD_I, ADDI_I:   alu_op = a + b;
      SUB_I:           alu_op = a - b;
      AND_I, ANDI_I:   alu_op = a & b;
      OR_I, ORI_I:     alu_op = a | b;
      XOR_I, XORI_I:   alu_op = a ^ b;
      SLT_I, SLTI_I:   alu_op = {{(DBITS-1){1'b0}}, as_v < bs_v};
      SLTU_I, SLTIU_I: alu_op = {{(DBITS-1){1'b0}}, a < b};
      SLL_I, SLLI_I:   alu_op = a << sh;
      SRL_I, SRLI_I:   alu_op = a >> sh;
      SRA_I, SRAI_I:   alu_op = as_v >>> sh;
      default:         alu_op = '0;
    endcase
  endfunction

  function automatic logic br_taken(input op_e o,
                                    input logic [DBITS-1:0] a,
                                    input logic [DBITS-1:0] b);
    logic signed [DBITS-1:0] as_v, bs_v;
    as_v = signed'(a);
    bs_v = signed'(b);
    case (o)
      BEQ_I:   br_taken = (a == b);
      BNE_I:   br_taken = (a != b);
      BLT_I:   br_taken = (as_v < bs_v);
      BGE_I:   br_taken = (as_v >= bs_v);
      BLTU_I:  br_taken = (a < b);
      BGEU_I:  br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  endfunction

  assign op        = op_e'(bus.op_i);
  assign rd        = bus.inst_i[11:7];
  assign squash_p0 = (squash_cnt != 2'd0);
  assign vld_p0    = bus.valid_i && !squash_p0;
  assign mul_start = vld_p0 && (op == MUL_I) && reset;
  assign mul_abort = !mul_start;
  assign jalr_sum  = bus.rs1_val_i + bus.imm_i;

  agex_mul_seq #(
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (bus.rs1_val_i),
    .b       (bus.rs2_val_i),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // ---- p0: execute on the DE latch fields ----
  // Result, rd-write and control-transfer decode per opcode
  always_comb begin
    result_p0 = '0;
    taken_p0  = 1'b0;
    target_p0 = bus.pc_i + bus.imm_i;
    wr_p0     = 1'b0;
    case (op)
      ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLT_I, SLTU_I, SRA_I, SRL_I, SLL_I: begin
        result_p0 = alu_op(op, bus.rs1_val_i, bus.rs2_val_i);
        wr_p0     = 1'b1;
      end
      ADDI_I, ANDI_I, ORI_I, XORI_I, SLTI_I, SLTIU_I, SRAI_I, SRLI_I, SLLI_I: begin
        result_p0 = alu_op(op, bus.rs1_val_i, bus.imm_i);
        wr_p0     = 1'b1;
      end
      MUL_I: begin
        result_p0 = mul_product;
        wr_p0     = 1'b1;
      end
      LUI_I: begin
        result_p0 = bus.imm_i;
        wr_p0     = 1'b1;
      end
      AUIPC_I: begin
        result_p0 = bus.pc_i + bus.imm_i;
        wr_p0     = 1'b1;
      end
      LW_I: begin
        result_p0 = jalr_sum;
        wr_p0     = 1'b1;
      end
      SW_I: begin
        result_p0 = jalr_sum;
      end
      JAL_I: begin
        result_p0 = bus.pcplus_i;
        wr_p0     = 1'b1;
        taken_p0  = 1'b1;
      end
      JALR_I: begin
        result_p0 = bus.pcplus_i;
        wr_p0     = 1'b1;
        taken_p0  = 1'b1;
        target_p0 = {jalr_sum[DBITS-1:1], 1'b0};
      end
      BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I: begin
        taken_p0 = br_taken(op, bus.rs1_val_i, bus.rs2_val_i);
      end
      default: begin
        result_p0 = '0;
      end
    endcase
  end

  // ---- p1: AGEX latch, redirect and squash window ----
  // A stalled MUL slot enters the latch as a bubble; a taken transfer opens
  // a two-slot squash window starting with the redirect cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      latch_p1       <= '0;
      redirect_p1    <= 1'b0;
      redirect_pc_p1 <= '0;
      squash_cnt     <= 2'd0;
    end else begin
      latch_p1.valid      <= vld_p0 && !mul_busy;
      latch_p1.inst       <= bus.inst_i;
      latch_p1.pc         <= bus.pc_i;
      latch_p1.op         <= bus.op_i;
      latch_p1.inst_count <= bus.inst_count_i;
      latch_p1.result     <= result_p0;
      latch_p1.store_data <= bus.rs2_val_i;
      latch_p1.wr_reg     <= vld_p0 && !mul_busy && wr_p0 && (rd != '0);
      latch_p1.wregno     <= rd;
      redirect_p1         <= vld_p0 && taken_p0;
      redirect_pc_p1      <= target_p0;
      if (vld_p0 && taken_p0) begin
        squash_cnt <= 2'd2;
      end else if (squash_cnt != 2'd0) begin
        squash_cnt <= squash_cnt - 2'd1;
      end
    end
  end

  assign bus.stall_o       = mul_busy;
  assign bus.agex_wregno_o = latch_p1.wregno;
  assign bus.agex_wr_reg_o = latch_p1.wr_reg;
  assign bus.redirect_o    = redirect_p1;
  assign bus.redirect_pc_o = redirect_pc_p1;
  assign bus.valid_o       = latch_p1.valid;
  assign bus.inst_o        = latch_p1.inst;
  assign bus.pc_o          = latch_p1.pc;
  assign bus.inst_count_o  = latch_p1.inst_count;
  assign bus.op_o          = latch_p1.op;
  assign bus.result_o      = latch_p1.result;
  assign bus.store_data_o  = latch_p1.store_data;
  assign bus.wr_reg_o      = latch_p1.wr_reg;
  assign bus.wregno_o      = latch_p1.wregno;

endmodule

// File: tb/tb_agex_stage.sv
// Directed bench for agex_stage with MUL_LAT = 4.
module tb_agex_stage;
  import agex_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

  agex_if bus ();

  agex_stage #(
    .MUL_LAT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_e o, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] pcplus, input logic [4:0] rd);
    bus.valid_i      = 1'b1;
    bus.op_i         = o;
    bus.rs1_val_i    = rs1;
    bus.rs2_val_i    = rs2;
    bus.imm_i        = imm;
    bus.pc_i         = pc;
    bus.pcplus_i     = pcplus;
    bus.inst_i       = {20'd0, rd, 7'h33};
    bus.inst_count_i = bus.inst_count_i + 32'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen;
    n_cmp = 0;
    n_mis = 0;
    bus.inst_count_i = 32'd0;

    // Reset held for two cycles with a valid ADD presented
    reset = 1'b0;
    drive(ADD_I, 32'd1, 32'd2, 32'd0, 32'h0, 32'h4, 5'd3);
    tick();
    tick();
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_redirect", bus.redirect_o, 1'b0);
    chk("rst_stall", bus.stall_o, 1'b0);
    chk("rst_result", bus.result_o, 32'h0);

    // ADDI wraps to zero; rd=5 writes, rd=0 does not
    reset = 1'b1;
    drive(ADDI_I, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h10, 32'h14, 5'd5);
    tick();
    chk("addi_valid", bus.valid_o, 1'b1);
    chk("addi_result", bus.result_o, 32'h0);
    chk("addi_wr", bus.wr_reg_o, 1'b1);
    chk("addi_wregno", bus.wregno_o, 5'd5);
    drive(ADDI_I, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h14, 32'h18, 5'd0);
    tick();
    chk("addi_rd0_wr", bus.wr_reg_o, 1'b0);
    chk("addi_rd0_agex_wr", bus.agex_wr_reg_o, 1'b0);

    // BLT taken: -1 < 1, target 0x100 - 8
    drive(BLT_I, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 32'h104, 5'd0);
    tick();
    chk("blt_redirect", bus.redirect_o, 1'b1);
    chk("blt_target", bus.redirect_pc_o, 32'hF8);
    chk("blt_wr", bus.wr_reg_o, 1'b0);
    drive(ADD_I, 32'd10, 32'd20, 32'd0, 32'h104, 32'h108, 5'd4);
    tick();
    chk("squash1_valid", bus.valid_o, 1'b0);
    chk("squash1_redirect", bus.redirect_o, 1'b0);
    tick();
    chk("squash2_valid", bus.valid_o, 1'b0);
    drive(ADD_I, 32'd7, 32'd8, 32'd0, 32'hF8, 32'hFC, 5'd4);
    tick();
    chk("post_squash_valid", bus.valid_o, 1'b1);
    chk("post_squash_result", bus.result_o, 32'd15);

    // MUL: three stall cycles, then the low word of the product
    drive(MUL_I, 32'h0001_0000, 32'h0001_0003, 32'd0, 32'hFC, 32'h100, 5'd6);
    #1;
    chk("mul_stall_first", bus.stall_o, 1'b1);
    n = 0;
    while (bus.stall_o && n < 10) begin
      tick();
      n++;
      chk("mul_bubble", bus.valid_o, 1'b0);
    end
    chk("mul_stall_cycles", 64'(n), 64'd3);
    tick();
    chk("mul_valid", bus.valid_o, 1'b1);
    chk("mul_result", bus.result_o, 32'h0003_0000);
    chk("mul_wregno", bus.wregno_o, 5'd6);

    // JALR: target clears bit 0, link is pcplus
    drive(JALR_I, 32'h203, 32'd0, 32'd0, 32'h40, 32'h44, 5'd1);
    tick();
    chk("jalr_redirect", bus.redirect_o, 1'b1);
    chk("jalr_target", bus.redirect_pc_o, 32'h202);
    chk("jalr_result", bus.result_o, 32'h44);
    chk("jalr_wr", bus.wr_reg_o, 1'b1);
    bus.valid_i = 1'b0;
    tick();
    tick();

    // Reset during the second BUSY cycle of a MUL
    drive(MUL_I, 32'd3, 32'd5, 32'd0, 32'h202, 32'h206, 5'd7);
    tick();
    tick();
    chk("mulrst_busy", bus.stall_o, 1'b1);
    reset = 1'b0;
    tick();
    chk("mulrst_stall", bus.stall_o, 1'b0);
    chk("mulrst_valid", bus.valid_o, 1'b0);
    reset = 1'b1;
    bus.valid_i = 1'b0;
    #1;
    chk("mulrst_stall_after", bus.stall_o, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | bus.valid_o;
    end
    chk("mulrst_no_result", seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/agex_stage.md
Name: agex_stage

Overview:
- Execute/address-generation stage directly downstream of decode. It consumes the DE latch fields: valid, inst, PC, pcplus, internal op, inst count, sign-extended immediate, rs1 value and rs2 value.
- Computes ALU, MUL, load/store address and branch/jump outcome, and registers the result into the AGEX latch for the MEM stage.
- Drives a stall back to DE for multi-cycle MUL and a PC redirect to FE for taken branches and jumps.
- Squashes wrong-path instructions after a redirect.

Parameters:
- DBITS, 32, datapath width.
- IOPBITS, 6, internal opcode width.
- REGNOBITS, 5, register-number width.
- MUL_LAT, 4, MUL latency in cycles (legal range 1..32).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-low (0 = reset).
- valid_i  in  1  DE latch valid.
- inst_i  in  32  instruction word.
- pc_i  in  DBITS  instruction PC.
- pcplus_i  in  DBITS  PC+4.
- op_i  in  IOPBITS  internal opcode.
- inst_count_i  in  DBITS  instruction sequence number.
- imm_i  in  DBITS  sign-extended immediate.
- rs1_val_i  in  DBITS  source 1 value.
- rs2_val_i  in  DBITS  source 2 value.
- stall_o  out  1  to DE: hold the current inputs stable.
- agex_wregno_o  out  REGNOBITS  rd of the instruction in the latch, for DE hazard check.
- agex_wr_reg_o  out  1  latched instruction writes rd.
- redirect_o  out  1  to FE: one-cycle pulse, load redirect_pc_o.
- redirect_pc_o  out  DBITS  new fetch PC.
- valid_o  out  1  AGEX latch valid.
- inst_o, pc_o, inst_count_o  out  32/DBITS/DBITS  passed through.
- op_o  out  IOPBITS  passed through.
- result_o  out  DBITS  ALU/MUL/link result or memory address.
- store_data_o  out  DBITS  rs2 value for SW.
- wr_reg_o  out  1  writes rd.
- wregno_o  out  REGNOBITS  inst[11:7].

Behaviour:
- Reset (reset=0 at posedge):
  - All latch outputs, redirect_o and stall_o clear to 0.
  - FSM returns to IDLE; squash counter and MUL counter clear.
  - An in-flight MUL is aborted and produces no output.
- Single-cycle ops: inputs sampled at posedge T; results appear on the latch outputs after T.
- ALU ops (ADD/SUB/AND/OR/XOR/SLT/SLTU/SLL/SRL/SRA and I-forms):
  - Width is DBITS; add and subtract wrap modulo 2^DBITS.
  - Shift amount is operand2[4:0].
  - SLT compares signed; SLTU compares unsigned.
- LUI: result = imm. AUIPC: result = pc + imm.
- LW and SW: result = rs1 + imm.
  - SW: store_data_o = rs2, wr_reg_o = 0.
- Branches: compare rs1 and rs2 (BEQ/BNE/BLT/BGE signed; BLTU/BGEU unsigned); wr_reg_o = 0.
  - Predict-not-taken.
  - On taken: redirect_o = 1 for exactly one cycle, registered alongside the latch, with redirect_pc_o = pc + imm.
- JAL: always redirect to pc + imm; result = pcplus.
- JALR: redirect to (rs1 + imm) & ~1; result = pcplus.
- CSRR, CSRW and INVALID: pass through with wr_reg_o = 0 and result = 0.
- wr_reg_o is forced 0 when rd = 0.
- Squash:
  - The cycle redirect_o is high and the following cycle are the squash window, covering the 2 wrong-path slots in DE and FE.
  - Inputs presented in that window are treated as bubbles: valid_o = 0, no redirect, no MUL start.
  - A redirect arriving while the squash window is active is impossible, because squashed inputs cannot redirect.
- MUL FSM, states IDLE and BUSY:
  - In IDLE, with valid MUL on the inputs and MUL_LAT > 1: stall_o = 1 combinationally that cycle; go to BUSY with cnt = 1.
  - In BUSY: stall_o = 1 while cnt < MUL_LAT-1; cnt increments each cycle.
  - When cnt = MUL_LAT-1: stall_o = 0, result = low DBITS of rs1*rs2, and the latch is loaded; go to IDLE.
  - Total: the MUL is presented for MUL_LAT cycles and valid_o rises after the last one.
  - While stall_o = 1, valid_o = 0 (bubble to MEM).
  - Upstream holds inputs stable during stall; operands are read live.
  - With MUL_LAT = 1, MUL is single-cycle and stall_o never rises.
- Back-to-back MULs: each incurs the full latency; the FSM passes through IDLE for 0 cycles (immediate restart).
- Invalid input (valid_i = 0): valid_o = 0 and all enables are 0. Data fields are don't-care but deterministic (not X).

Decomposition:
- Shared package (defines header) holds:
  - internal opcode constants (ADD_I..INVALID_I);
  - DBITS, REGNOBITS, IOPBITS;
  - AGEX latch field order and width (AGEX_latch_WIDTH);
  - from_AGEX_to_DE and from_AGEX_to_FE widths.
- One sub-module, agex_mul_seq: holds the MUL FSM and counter. Inputs start/abort; outputs busy/done/product.
- The ALU and branch compare stay inline.

Test Plan:
- Reset: hold reset=0 for 2 cycles with valid ADD on the inputs -> valid_o=0, redirect_o=0, stall_o=0.
- ADDI: rs1=0xFFFFFFFF, imm=1, rd=5 -> next cycle result_o=0x00000000, wr_reg_o=1, wregno_o=5. Same with rd=0 -> wr_reg_o=0.
- BLT: rs1=-1, rs2=1, pc=0x100, imm=-8 -> redirect_o high for 1 cycle with redirect_pc_o=0xF8.
  - The next 2 inputs (valid ADDs) give valid_o=0.
  - The third input emerges valid.
- MUL with MUL_LAT=4: 0x00010000*0x00010003 -> stall_o high for exactly 3 cycles, then valid_o=1 with result_o=0x00030000.
- JALR: rs1=0x203, imm=0, pcplus=0x44 -> redirect_pc_o=0x202, result_o=0x44.
- Reset asserted during the 2nd BUSY cycle of a MUL -> FSM in IDLE; no MUL result ever appears; stall_o=0 after reset.
